// File: rtl/core_pkg.sv
// Shared constants and small helpers for the fetch stage of the 5-stage MIPS core.
package core_pkg;

  localparam int XLEN = 32;

  // Instruction encoding field positions (MIPS32)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int FUNC_W     = FUNC_MSB - FUNC_LSB + 1;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  // Upper PC bits preserved across a J-type jump
  localparam int PC_REGION_MSB = 31;
  localparam int PC_REGION_LSB = 28;

  // sll $0,$0,0 -- the architectural NOP used for pipeline bubbles
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;
  localparam logic [XLEN-1:0] WORD_MASK = 32'h0000_0003;

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~WORD_MASK;
  endfunction

endpackage : core_pkg

// File: rtl/fetch_stage_if.sv
// Bundle of hazard/redirect controls, instruction-memory bus and IF/ID outputs.
interface fetch_stage_if;
  import core_pkg::*;

  // Controls from hazard unit and decoder
  logic                stallF;
  logic                stallD;
  logic                pcSrcD;
  logic                jump;
  logic                clearD;
  logic [XLEN-1:0]     pcBranchD;

  // Harvard instruction-memory port
  logic [XLEN-1:0]     imemAddr;
  logic [XLEN-1:0]     imemData;

  // IF/ID register contents presented to decode
  logic [XLEN-1:0]     instrD;
  logic [OPCODE_W-1:0] opCodeD;
  logic [FUNC_W-1:0]   funcD;
  logic [XLEN-1:0]     pcPlus4D;
  logic                validD;

  // Environment side: hazard unit, decoder and instruction memory
  modport master (
    output stallF, stallD, pcSrcD, jump, clearD, pcBranchD, imemData,
    input  imemAddr, instrD, opCodeD, funcD, pcPlus4D, validD
  );

  // Fetch stage side
  modport slave (
    input  stallF, stallD, pcSrcD, jump, clearD, pcBranchD, imemData,
    output imemAddr, instrD, opCodeD, funcD, pcPlus4D, validD
  );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+4.
// A stall (en low) holds everything and takes priority over a flush, so a
// redirect computed from stale operands during a stall cannot kill the
// instruction waiting in decode.
module if_id_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] pc_plus4_r;
  logic            valid_r;

  // Register update: reset bubble, then stall hold, then flush bubble, then load
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (!en) begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end else if (clr) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else begin
      instr_r    <= instr_in;
      pc_plus4_r <= pc_plus4_in;
      valid_r    <= 1'b1;
    end
  end

  assign instr    = instr_r;
  assign pc_plus4 = pc_plus4_r;
  assign valid    = valid_r;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. The PC register drives the instruction-memory address
// directly, so imemAddr is a registered output.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] jump_target_s;
  logic [XLEN-1:0] next_pc_s;

  assign pc_plus4_s = pc_r + PC_STEP;

  // J-type target keeps the region bits of the jump's own PC+4
  assign jump_target_s = {bus.pcPlus4D[PC_REGION_MSB:PC_REGION_LSB],
                          bus.instrD[JIDX_MSB:JIDX_LSB], 2'b00};

  // Next-PC select: stall holds, jump beats branch, otherwise sequential
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (bus.stallF) begin
      next_pc_s = pc_r;
    end else if (bus.jump) begin
      next_pc_s = align_pc(jump_target_s);
    end else if (bus.pcSrcD) begin
      next_pc_s = align_pc(bus.pcBranchD);
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // PC register; reset overrides stalls and redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= align_pc(RESET_PC);
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign bus.imemAddr = pc_r;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .en          (~bus.stallD),
    .clr         (bus.clearD),
    .instr_in    (bus.imemData),
    .pc_plus4_in (pc_plus4_s),
    .instr       (bus.instrD),
    .pc_plus4    (bus.pcPlus4D),
    .valid       (bus.validD)
  );

  // Field slices handed to the control decoder
  assign bus.opCodeD = bus.instrD[OPCODE_MSB:OPCODE_LSB];
  assign bus.funcD   = bus.instrD[FUNC_MSB:FUNC_LSB];

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Instruction memory model:
// address 0x1000_0004 holds the J instruction 0x0800_0040, every other
// address A holds {8'hAC, A[23:0]}.
module tb_fetch_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if bus ();
  fetch_stage_if bus_w ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0040;
    else return {8'hAC, a[23:0]};
  endfunction

  assign bus.imemData   = mem_word(bus.imemAddr);
  assign bus_w.imemData = mem_word(bus_w.imemAddr);

  assign bus_w.stallF    = 1'b0;
  assign bus_w.stallD    = 1'b0;
  assign bus_w.pcSrcD    = 1'b0;
  assign bus_w.jump      = 1'b0;
  assign bus_w.clearD    = 1'b0;
  assign bus_w.pcBranchD = 32'h0000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic sf, input logic sd, input logic ps,
                         input logic jp, input logic cl, input logic [31:0] tgt);
    bus.stallF    = sf;
    bus.stallD    = sd;
    bus.pcSrcD    = ps;
    bus.jump      = jp;
    bus.clearD    = cl;
    bus.pcBranchD = tgt;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v);
    check({tag, "_pc"},    bus.imemAddr, pc);
    check({tag, "_instr"}, bus.instrD, ins);
    check({tag, "_pc4"},   bus.pcPlus4D, p4);
    check({tag, "_valid"}, {31'd0, bus.validD}, {31'd0, v});
  endtask

  initial begin
    // Reset held two cycles while controls toggle
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    check_d("reset", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    check("reset_op",   {26'd0, bus.opCodeD}, 32'h0000_0000);
    check("reset_func", {26'd0, bus.funcD},   32'h0000_0000);
    check("reset_w_pc", bus_w.imemAddr, 32'hFFFF_FFF8);

    // Release: first fetch
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    #1;
    check("release_pc", bus.imemAddr, 32'h0000_0000);
    tick();
    check_d("fetch0", 32'h0000_0004, 32'hAC00_0000, 32'h0000_0004, 1'b1);
    check("fetch0_op", {26'd0, bus.opCodeD}, 32'h0000_002B);
    check("wrap_pc1",  bus_w.imemAddr, 32'hFFFF_FFFC);
    check("wrap_pc4a", bus_w.pcPlus4D, 32'hFFFF_FFFC);
    check("wrap_ins1", bus_w.instrD, 32'hACFF_FFF8);
    tick();
    check_d("fetch1", 32'h0000_0008, 32'hAC00_0004, 32'h0000_0008, 1'b1);
    check("wrap_pc2",  bus_w.imemAddr, 32'h0000_0000);
    check("wrap_pc4b", bus_w.pcPlus4D, 32'h0000_0000);
    check("wrap_ins2", bus_w.instrD, 32'hACFF_FFFC);

    // Taken branch with misaligned target bits
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    check_d("br_bubble", 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check_d("br_target", 32'h0000_0104, 32'hAC00_0100, 32'h0000_0104, 1'b1);

    // Steer to the J instruction at 0x1000_0004
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0004);
    tick();
    check_d("to_j", 32'h1000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check_d("j_in_d", 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1);
    check("j_op", {26'd0, bus.opCodeD}, 32'h0000_0002);

    // Jump and branch together: jump wins
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    tick();
    check_d("jump", 32'h1000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check_d("jump_tgt", 32'h1000_0104, 32'hAC00_0100, 32'h1000_0104, 1'b1);

    // Stall overrides flush and redirect for three cycles
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_d("stall", 32'h1000_0104, 32'hAC00_0100, 32'h1000_0104, 1'b1);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check_d("resume", 32'h1000_0108, 32'hAC00_0104, 32'h1000_0108, 1'b1);
    check("resume_func", {26'd0, bus.funcD}, 32'h0000_0004);

    // Reset pulse during a stall
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    rst = 1'b1;
    tick();
    check_d("rst_stall", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check_d("after_rst", 32'h0000_0004, 32'hAC00_0000, 32'h0000_0004, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS core. Holds the program counter, selects the next PC from sequential, branch and jump sources, and drives the Harvard instruction-memory address. Registers the fetched instruction into the decode stage, where opCode/func are sliced off for the control decoder. Consumes the decoder's branch/jump redirect and flush outputs plus the hazard unit's stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stallF  in  1  hold PC (hazard unit)
- stallD  in  1  hold IF/ID register (hazard unit)
- pcSrcD  in  1  taken branch resolved in decode
- jump  in  1  jump decoded in decode
- clearD  in  1  flush IF/ID (pcSrcD | jump)
- pcBranchD  in  32  branch target computed in decode
- imemData  in  32  instruction-memory read data, combinational on imemAddr
- imemAddr  out  32  instruction-memory address (= pcF)
- instrD  out  32  registered instruction
- opCodeD  out  6  instrD[31:26]
- funcD  out  6  instrD[5:0]
- pcPlus4D  out  32  registered pcF+4
- validD  out  1  instrD holds a real fetched instruction (0 = bubble)

## Operation
- pcPlus4F = pcF + 4, modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- jumpTarget = {pcPlus4D[31:28], instrD[25:0], 2'b00}.
- Next-PC priority: rst -> RESET_PC; stallF -> hold; jump -> jumpTarget; pcSrcD -> pcBranchD; else pcPlus4F.
- jump and pcSrcD both high: jump wins.
- Next PC has bits [1:0] forced to 00; pcBranchD[1:0] ignored.
- IF/ID priority: rst -> bubble; stallD -> hold all of instrD/pcPlus4D/validD; clearD -> bubble; else load instrD = imemData, pcPlus4D = pcPlus4F, validD = 1.
- stallD overrides clearD: a redirect evaluated on stale operands during a stall must not flush.
- Bubble: instrD = 32'h0 (sll $0,$0,0 = NOP), pcPlus4D = 0, validD = 0.
- opCodeD and funcD are pure slices of instrD; no extra logic.
- PC state machine (two states, encoded in validD/pcF): RESET (after rst, instrD bubble, pcF = RESET_PC) -> RUN on first cycle with rst low; RUN -> RESET only on rst.

## Timing
- Reset values: pcF/imemAddr = RESET_PC, instrD = 0, opCodeD = 0, funcD = 0, pcPlus4D = 0, validD = 0.
- imemAddr is registered; imemData is sampled the same cycle (combinational memory).
- Fetch-to-decode latency: 1 cycle; instruction at address A appears on instrD the edge after pcF = A, unless stalled/cleared.
- Redirect: pcSrcD/jump sampled at edge N loads target into pcF at N; target instruction reaches instrD at N+1; the instruction fetched during N-1..N is flushed by clearD (one bubble).
- stallF and stallD independent; stallF=1, stallD=0 with clearD=0 re-registers the same instruction (hazard unit must not request this).
- rst mid-operation: all state reset at next edge regardless of stalls, clearD or redirects.

## Structure
- Shared package core_pkg: NOP_INSTR = 32'h0, OPCODE/FUNC bit-field position constants, XLEN = 32.
- One sub-module natural: if_id_reg (instrD/pcPlus4D/validD with en/clr, stall-over-clear priority); PC register and next-PC mux stay in fetch_stage.

## Test plan
- Reset: rst high 2 cycles with stalls/jump toggling -> imemAddr = RESET_PC, instrD = 0, validD = 0; first cycle after release imemAddr = RESET_PC, next cycle 0x4 and instrD = mem[0], validD = 1.
- Sequential wrap: RESET_PC = 32'hFFFF_FFF8 -> imemAddr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pcPlus4D follows +4 mod 2^32.
- Branch: pcSrcD = 1, clearD = 1, pcBranchD = 0x0000_0103 -> next imemAddr = 0x100, instrD bubble (0, validD = 0) for one cycle, then mem[0x100].
- Jump vs branch: instrD = 0x0800_0040 at pcPlus4D = 0x1000_0008, jump = pcSrcD = 1, pcBranchD = 0x200 -> next imemAddr = 0x1000_0100.
- Stall priority: stallF = stallD = 1 with clearD = 1, pcSrcD = 1 for 3 cycles -> pcF, instrD, validD unchanged; release -> normal fetch resumes from held pcF.
- Reset mid-stall: stallF = stallD = 1, rst pulsed 1 cycle -> pcF = RESET_PC, validD = 0 on that edge.
